// File: rtl/chaotic_stream_reader_pkg.sv
// Shared types and constants for the chaotic-stream reader: FSM states,
// IEEE-754 exponent field position and the FIFO level width helper.
package chaotic_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam int EXP_MSB = 62;
  localparam int EXP_LSB = 52;

  // A level counter must hold 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/chaotic_stream_reader_if.sv
// Sample-in / word-out stream bundle between the chaotic core, the reader
// and the downstream scrambler.
interface chaotic_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] xn1;
  logic [DATA_WIDTH-1:0] yn1;
  logic [DATA_WIDTH-1:0] zn1;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_WIDTH-1:0]  out_data;

  modport master (
    output in_valid, xn1, yn1, zn1, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, xn1, yn1, zn1, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/chaotic_stream_reader_fifo.sv
// First-word-fall-through synchronous FIFO for packed words; a push into a
// full FIFO is taken only when a pop frees the head slot on the same edge.
module chaotic_word_fifo
  import chaotic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int LW = level_width(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/chaotic_stream_reader.sv
// Drops the chaotic transient, XOR-folds one byte of x/y/z per sample and
// packs bytes LSB-first into words. CHAOTIC_READER_NAN_FILTER_EN adds Inf/NaN/zero rejection.
module chaotic_stream_reader
  import chaotic_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int OUT_WIDTH     = 32,
  parameter int LSB_OFFSET    = 0,
  parameter int DISCARD_COUNT = 256,
  parameter int FIFO_DEPTH    = 16,
  localparam int LW = level_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  chaotic_stream_if.slave  strm,
  output logic             warmup_done,
  output logic [LW-1:0]    fifo_level,
  output logic [15:0]      drop_cnt
`ifdef CHAOTIC_READER_NAN_FILTER_EN
  ,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int SPW = OUT_WIDTH / 8;
  localparam int KW  = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int CW  = (DISCARD_COUNT > 1) ? $clog2(DISCARD_COUNT) : 1;
  localparam logic [KW-1:0] K_LAST    = KW'(SPW - 1);
  localparam logic [CW-1:0] DISC_LAST = CW'(DISCARD_COUNT - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       disc_q, disc_d;
  logic [KW-1:0]       k_q, k_d;
  logic [OUT_WIDTH-1:0] pack_q, pack_d;
  logic                word_done_q, word_done_d;
  logic [15:0]         drop_q, drop_d;
  logic                accept;
  logic                sample_ok;
  logic [7:0]          chunk;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;

  assign accept = strm.in_valid && enable;
  assign chunk  = strm.xn1[LSB_OFFSET +: 8] ^ strm.yn1[LSB_OFFSET +: 8] ^ strm.zn1[LSB_OFFSET +: 8];

`ifdef CHAOTIC_READER_NAN_FILTER_EN
  logic        bad_sample;
  logic [15:0] rej_q, rej_d;

  function automatic logic exp_bad(input logic [DATA_WIDTH-1:0] v);
    return (&v[EXP_MSB:EXP_LSB]) | ~(|v[EXP_MSB:EXP_LSB]);
  endfunction

  assign bad_sample = exp_bad(strm.xn1) | exp_bad(strm.yn1) | exp_bad(strm.zn1);
  assign sample_ok  = accept && !bad_sample;

  always_comb begin
    rej_d = rej_q;
    if (accept && (state_q == RUN) && bad_sample && (rej_q != 16'hFFFF)) rej_d = rej_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rej_q <= '0;
    else     rej_q <= rej_d;
  end

  assign reject_cnt = rej_q;
`else
  assign sample_ok = accept;
`endif

  // Warm-up counting and RUN-time packing; word_done pulses for exactly one cycle.
  always_comb begin
    state_d     = state_q;
    disc_d      = disc_q;
    k_d         = k_q;
    pack_d      = pack_q;
    word_done_d = 1'b0;
    unique case (state_q)
      WARMUP: begin
        if (DISCARD_COUNT == 0) begin
          state_d = RUN;
        end else if (accept) begin
          if (disc_q == DISC_LAST) state_d = RUN;
          else                     disc_d  = disc_q + 1'b1;
        end
      end
      RUN: begin
        if (sample_ok) begin
          pack_d[8*k_q +: 8] = chunk;
          if (k_q == K_LAST) begin
            k_d         = '0;
            word_done_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign pop = strm.out_valid && strm.out_ready;

  // The packer never stalls, so a word arriving at a full FIFO is counted and lost.
  always_comb begin
    drop_d = drop_q;
    if (word_done_q && fifo_full && !pop && (drop_q != 16'hFFFF)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WARMUP;
      disc_q      <= '0;
      k_q         <= '0;
      pack_q      <= '0;
      word_done_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      disc_q      <= disc_d;
      k_q         <= k_d;
      pack_q      <= pack_d;
      word_done_q <= word_done_d;
      drop_q      <= drop_d;
    end
  end

  chaotic_word_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (word_done_q),
    .data_i  (pack_q),
    .pop_i   (strm.out_ready),
    .data_o  (strm.out_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign strm.out_valid = !fifo_empty;
  assign warmup_done    = (state_q == RUN);
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_chaotic_stream_reader.sv
// Scoreboard bench for chaotic_stream_reader: a queue-based predictor of the
// byte stream and FIFO occupancy feeds expected words to a decoupled monitor.
module tb_chaotic_stream_reader;

  localparam int DW    = 64;
  localparam int OW    = 32;
  localparam int LSB   = 0;
  localparam int DISC  = 2;
  localparam int DEPTH = 16;
  localparam int SPW   = OW / 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          warmup_done;
  logic [LW-1:0] fifo_level;
  logic [15:0]   drop_cnt;
`ifdef CHAOTIC_READER_NAN_FILTER_EN
  logic [15:0]   reject_cnt;
`endif

  chaotic_stream_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) strm ();

  chaotic_stream_reader #(
    .DATA_WIDTH    (DW),
    .OUT_WIDTH     (OW),
    .LSB_OFFSET    (LSB),
    .DISCARD_COUNT (DISC),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .strm        (strm),
    .warmup_done (warmup_done),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
`ifdef CHAOTIC_READER_NAN_FILTER_EN
    ,
    .reject_cnt  (reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model state: expected FIFO words, partial bytes, counters.
  logic [OW-1:0] sb[$];
  logic [7:0]    part[$];
  int            mocc = 0;
  int            mcnt = 0;
  bit            mwarm = 0;
  bit            mpend = 0;
  logic [OW-1:0] mword = '0;
  int            mdrop = 0;
  int            mrej = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    v[62:52] = 11'h3FF;
    return v;
  endfunction

  function automatic bit expBad(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) || (v[62:52] == 11'h000);
  endfunction

  task automatic applyStimulus(input logic v, input logic en, input logic rdy,
                               input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
    @(posedge clk);
    #1;
    strm.in_valid  = v;
    enable         = en;
    strm.out_ready = rdy;
    strm.xn1       = x;
    strm.yn1       = y;
    strm.zn1       = z;
  endtask

  task automatic randSample(input logic rdy);
    applyStimulus(1'b1, 1'b1, rdy, rnd64(), rnd64(), rnd64());
  endtask

  task automatic idle(input logic rdy, input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, rdy, 64'd0, 64'd0, 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " out_valid"}, strm.out_valid, 0);
    checkOutput({tag, " out_data"}, strm.out_data, 0);
    checkOutput({tag, " warmup_done"}, warmup_done, 0);
    checkOutput({tag, " fifo_level"}, fifo_level, 0);
    checkOutput({tag, " drop_cnt"}, drop_cnt, 0);
`ifdef CHAOTIC_READER_NAN_FILTER_EN
    checkOutput({tag, " reject_cnt"}, reject_cnt, 0);
`endif
  endtask

  // Predictor: evaluates what the upcoming rising edge does from the inputs now held.
  always @(negedge clk) begin
    bit pop;
    bit take;
    if (rst) begin
      sb.delete();
      part.delete();
      mocc = 0; mcnt = 0; mwarm = 0; mpend = 0; mdrop = 0; mrej = 0;
    end else begin
      pop  = (mocc > 0) && strm.out_ready;
      take = 0;
      if (mpend) begin
        if (mocc < DEPTH || pop) begin
          sb.push_back(mword);
          take = 1;
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end
      mocc  = mocc - int'(pop) + int'(take);
      mpend = 0;
      if (strm.in_valid && enable) begin
        if (!mwarm) begin
          mcnt++;
          if (mcnt >= DISC) mwarm = 1;
        end else if (expBad(strm.xn1) || expBad(strm.yn1) || expBad(strm.zn1)) begin
`ifdef CHAOTIC_READER_NAN_FILTER_EN
          if (mrej < 65535) mrej++;
`else
          part.push_back(strm.xn1[LSB+:8] ^ strm.yn1[LSB+:8] ^ strm.zn1[LSB+:8]);
`endif
        end else begin
          part.push_back(strm.xn1[LSB+:8] ^ strm.yn1[LSB+:8] ^ strm.zn1[LSB+:8]);
        end
        if (part.size() == SPW) begin
          for (int i = 0; i < SPW; i++) mword[8*i +: 8] = part[i];
          part.delete();
          mpend = 1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs to the model and retires words on handshakes.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      checkOutput("out_valid", strm.out_valid, (mocc != 0));
      checkOutput("fifo_level", fifo_level, mocc);
      checkOutput("drop_cnt", drop_cnt, mdrop);
      checkOutput("warmup_done", warmup_done, mwarm);
`ifdef CHAOTIC_READER_NAN_FILTER_EN
      checkOutput("reject_cnt", reject_cnt, mrej);
`endif
      if (strm.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL out_data: got %h expected no word", strm.out_data);
        end else begin
          checkOutput("out_data", strm.out_data, sb[0]);
          if (strm.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    strm.in_valid  = 1'b0;
    strm.out_ready = 1'b0;
    strm.xn1 = '0; strm.yn1 = '0; strm.zn1 = '0;

    // Reset state, then release away from the edge.
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    #1 rst = 1'b0;

    // Directed: two discarded samples, then bytes 07,11,22,33.
    randSample(1'b1);
    randSample(1'b1);
    checkOutput("warmup before 2nd", warmup_done, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0002, 64'h3FF0_0000_0000_0004);
    checkOutput("warmup after 2nd", warmup_done, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h3FF0_0000_0000_0010, 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h3FF0_0000_0000_0020, 64'h3FF0_0000_0000_0002, 64'h3FF0_0000_0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h3FF0_0000_0000_0030, 64'h3FF0_0000_0000_0003, 64'h3FF0_0000_0000_0000);
    idle(1'b1, 1);
    checkOutput("latency cycle1 out_valid", strm.out_valid, 0);
    idle(1'b1, 1);
    checkOutput("latency cycle2 out_valid", strm.out_valid, 1);
    checkOutput("directed out_data", strm.out_data, 32'h33221107);
    idle(1'b1, 2);

    // Enable held low for ten pulses in the middle of a word.
    randSample(1'b1);
    randSample(1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, rnd64(), rnd64(), rnd64());
    checkOutput("enable hold level", fifo_level, 0);
    randSample(1'b1);
    randSample(1'b1);
    idle(1'b1, 3);

    // Randomized traffic with random enable and backpressure.
    for (int i = 0; i < 300; i++)
      applyStimulus(($urandom % 4) != 0, ($urandom % 8) != 0, $urandom % 2, rnd64(), rnd64(), rnd64());
    idle(1'b1, 40);

    // Asynchronous reset mid-word with three buffered words.
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (DISC + 3 * SPW + 2) randSample(1'b0);
    idle(1'b0, 2);
    checkOutput("pre-reset level", fifo_level, 3);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkResetOutputs("async reset");
    @(posedge clk); #2 rst = 1'b0;
    randSample(1'b0);
    randSample(1'b0);
    checkOutput("rediscard warmup", warmup_done, 0);
    idle(1'b0, 1);
    checkOutput("rediscard done", warmup_done, 1);

    // Backpressure: one word more than the FIFO holds.
    repeat ((DEPTH + 1) * SPW) randSample(1'b0);
    idle(1'b0, 2);
    checkOutput("full level", fifo_level, DEPTH);
    checkOutput("full drop", drop_cnt, 1);

    // A word lands on the same edge that pops a full FIFO.
    repeat (SPW) randSample(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'd0, 64'd0, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    checkOutput("same-edge level", fifo_level, DEPTH);
    checkOutput("same-edge drop", drop_cnt, 1);

    // Drain in order.
    idle(1'b1, DEPTH);
    idle(1'b0, 1);
    checkOutput("drained level", fifo_level, 0);

`ifdef CHAOTIC_READER_NAN_FILTER_EN
    // A NaN sample between valid samples is skipped by the packer.
    randSample(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, rnd64(), 64'h7FF8_0000_0000_0000, rnd64());
    repeat (SPW - 1) randSample(1'b1);
    idle(1'b1, 3);
    checkOutput("nan reject_cnt", reject_cnt, 1);
`endif

    idle(1'b1, 4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
